// File: rtl/coulomb_accum_pipe.sv
// Three-stage fixed-point Coulomb force pipeline (q_i*q_j*r2_inv*KC) with a
// per-atom accumulator that reports the summed force on the atom's last pair.
module coulomb_accum_pipe #(
  parameter int             W         = 32,
  parameter int             FRAC      = 16,
  parameter logic [W-1:0]   KC        = 32'h014C1000,
  parameter int             ACC_W     = 40,
  parameter bit             SAT_EN    = 1'b1,
  parameter logic [W-1:0]   R2INV_MIN = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_last,
  input  logic [W-1:0]       q_i,
  input  logic [W-1:0]       q_j,
  input  logic [W-1:0]       r2_inv,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [W-1:0]       f_scalar,
  output logic               out_last,
  output logic [ACC_W-1:0]   f_sum,
  output logic               sum_valid,
  output logic               sat_flag
);

  localparam logic signed [2*W-1:0] QMAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] QMIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

  // Returns {saturated, result}: Q-format product, floor-shifted, reduced to W bits.
  function automatic logic [W:0] qmult(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] prod;
    prod = $signed({{W{a[W-1]}}, a} * {{W{b[W-1]}}, b});
    prod = prod >>> FRAC;
    if (SAT_EN && (prod > QMAX)) begin
      return {1'b1, 1'b0, {(W-1){1'b1}}};
    end else if (SAT_EN && (prod < QMIN)) begin
      return {1'b1, 1'b1, {(W-1){1'b0}}};
    end else begin
      return {1'b0, prod[W-1:0]};
    end
  endfunction

  // Returns {saturated, sum} of the accumulator and a sign-extended force.
  function automatic logic [ACC_W:0] acc_add(input logic [ACC_W-1:0] acc, input logic [W-1:0] f);
    logic [ACC_W:0] s;
    s = {acc[ACC_W-1], acc} + {{(ACC_W+1-W){f[W-1]}}, f};
    if (SAT_EN && (s[ACC_W] != s[ACC_W-1])) begin
      return s[ACC_W] ? {1'b1, 1'b1, {(ACC_W-1){1'b0}}} : {1'b1, 1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      return {1'b0, s[ACC_W-1:0]};
    end
  endfunction

  logic             adv_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [W:0]       s1_qq_s;
  logic [W-1:0]     r2_sel_s;
  logic [W:0]       s2_res_s;
  logic [W:0]       s3_res_s;
  logic [ACC_W:0]   acc_res_s;
  logic             sat_hit_s;

  logic             s1_valid_r;
  logic             s1_last_r;
  logic [W-1:0]     s1_qq_r;
  logic [W-1:0]     s1_r2_r;
  logic             s2_valid_r;
  logic             s2_last_r;
  logic [W-1:0]     s2_f_r;
  logic [ACC_W-1:0] acc_r;

  // Handshake, per-stage arithmetic and saturation detection.
  always_comb begin
    adv_s      = !out_valid || out_ready;
    in_xfer_s  = in_valid && adv_s;
    out_xfer_s = out_valid && out_ready;
    s1_qq_s    = qmult(q_i, q_j);
    if ($signed(r2_inv) < $signed(R2INV_MIN)) begin
      r2_sel_s = '0;
    end else begin
      r2_sel_s = r2_inv;
    end
    s2_res_s   = qmult(s1_qq_r, s1_r2_r);
    s3_res_s   = qmult(s2_f_r, KC);
    acc_res_s  = acc_add(acc_r, f_scalar);
    sat_hit_s  = (in_xfer_s && s1_qq_s[W])
              || (adv_s && s1_valid_r && s2_res_s[W])
              || (adv_s && s2_valid_r && s3_res_s[W])
              || (out_xfer_s && acc_res_s[ACC_W]);
  end

  assign in_ready = adv_s;

  // Pipeline stages, accumulator and sticky saturation flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_last_r  <= 1'b0;
      s1_qq_r    <= '0;
      s1_r2_r    <= '0;
      s2_valid_r <= 1'b0;
      s2_last_r  <= 1'b0;
      s2_f_r     <= '0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      f_scalar   <= '0;
      acc_r      <= '0;
      f_sum      <= '0;
      sum_valid  <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      if (adv_s) begin
        s1_valid_r <= in_valid;
        s1_last_r  <= in_valid && in_last;
        s1_qq_r    <= s1_qq_s[W-1:0];
        s1_r2_r    <= r2_sel_s;
        s2_valid_r <= s1_valid_r;
        s2_last_r  <= s1_last_r;
        s2_f_r     <= s2_res_s[W-1:0];
        out_valid  <= s2_valid_r;
        out_last   <= s2_last_r;
        f_scalar   <= s3_res_s[W-1:0];
      end
      // A last beat always closes the atom, even when its sum saturated.
      if (out_xfer_s) begin
        if (out_last) begin
          f_sum     <= acc_res_s[ACC_W-1:0];
          sum_valid <= 1'b1;
          acc_r     <= '0;
        end else begin
          acc_r     <= acc_res_s[ACC_W-1:0];
          sum_valid <= 1'b0;
        end
      end else begin
        sum_valid <= 1'b0;
      end
      if (sat_hit_s) begin
        sat_flag <= 1'b1;
      end
    end
  end

endmodule
